instr_fetch: RTL

Fetch stage directly upstream of the control unit. Holds the PC and issues word requests to instruction memory over a req/ready handshake. Presents one instruction at a time on ins/ins_valid to decode and the control unit. Takes branch/jump redirects from the execute side, which raises redirect when pcloadEn and the branch condition resolve.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 10 +
 rtl/instr_fetch_pc_reg.sv | 27 ++
 rtl/instr_fetch.sv | 109 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants, opcodes and fetch FSM state used by fetch and control.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INS_DEF  = 32'h0000_0013;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response bus between fetch (master) and imem (slave).
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/instr_fetch_pc_reg.sv
// PC register: word-aligned load, +4 increment, reset to a fixed PC.
// Latency 1 cycle from load/inc to pc; pc_plus4 is combinational.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [29:0] load_word,
    input  logic        inc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= {load_word, 2'b00};
        end else if (inc) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues word requests, presents one instruction at a time, takes redirects.
// Latency 1 cycle imem_ready->ins_valid; stall holds ins/pc, redirect overrides stall.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INS  = NOP_INS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_if.master        imem,
    output logic [31:0]          ins,
    output logic                 ins_valid,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_target,
    output logic                 misalign_err
);

    fetch_state_t state;
    logic         req_q;
    logic [29:0]  redir_pc;
    logic         pc_load;
    logic         pc_inc;
    logic [29:0]  pc_load_word;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .load_word (pc_load_word),
        .inc       (pc_inc),
        .pc        (pc),
        .pc_plus4  (pc_plus4)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    // A fresh redirect always beats the saved target when the flushed response lands.
    always_comb begin
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load_word = redirect_target[31:2];
        case (state)
            FETCH: pc_load = imem.imem_ready & redirect;
            FLUSH: begin
                if (imem.imem_ready) begin
                    pc_load = 1'b1;
                    if (!redirect) pc_load_word = redir_pc;
                end
            end
            VALID: begin
                if (redirect)    pc_load = 1'b1;
                else if (!stall) pc_inc  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            req_q        <= 1'b1;
            ins          <= NOP_INS;
            ins_valid    <= 1'b0;
            misalign_err <= 1'b0;
            redir_pc     <= '0;
        end else begin
            if (redirect && misaligned(redirect_target)) misalign_err <= 1'b1;
            case (state)
                FETCH: begin
                    if (imem.imem_ready && !redirect) begin
                        ins       <= imem.imem_rdata;
                        ins_valid <= 1'b1;
                        req_q     <= 1'b0;
                        state     <= VALID;
                    end else if (!imem.imem_ready && redirect) begin
                        // Request already on the bus must complete before the new address.
                        redir_pc <= redirect_target[31:2];
                        state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (imem.imem_ready) begin
                        state <= FETCH;
                    end else if (redirect) begin
                        redir_pc <= redirect_target[31:2];
                    end
                end
                VALID: begin
                    if (redirect || !stall) begin
                        ins       <= NOP_INS;
                        ins_valid <= 1'b0;
                        req_q     <= 1'b1;
                        state     <= FETCH;
                    end
                end
                default: begin
                    req_q <= 1'b1;
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
